// File: rtl/counter_sequencer.sv
// Command-driven 2-bit position sequencer: accepts a direction and step count,
// then steps the position once per prescaler tick until done or aborted.
module counter_sequencer #(
    parameter int unsigned      DIV_W   = 26,
    parameter logic [DIV_W-1:0] DIV_MAX = 26'd49_999_999
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic       cmd_dir,
    input  logic [3:0] cmd_steps,
    input  logic       abort,
    output logic       cmd_ready,
    output logic [3:0] ClockValue,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic [3:0] remaining
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       position;
    logic             dir_q;
    logic [DIV_W-1:0] prescaler;
    logic [3:0]       remaining_q;
    logic             aborted_q;

    logic accept;
    logic tick;
    logic step;
    logic last_step;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        accept     = (state == IDLE) && cmd_valid;
        tick       = (state == RUN) && (prescaler == DIV_MAX);
        step       = tick && !abort;
        last_step  = step && (remaining_q == 4'd1);
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (cmd_steps != 4'd0) ? RUN : DONE;
            RUN:  if (abort || last_step) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort wins over a coincident tick: position and remaining are frozen in that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            position    <= 2'd0;
            dir_q       <= 1'b0;
            prescaler   <= '0;
            remaining_q <= 4'd0;
            aborted_q   <= 1'b0;
        end else if (accept) begin
            dir_q       <= cmd_dir;
            remaining_q <= cmd_steps;
            prescaler   <= '0;
            aborted_q   <= 1'b0;
        end else if (state == RUN) begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (abort) begin
                aborted_q <= 1'b1;
            end else if (step) begin
                position    <= dir_q ? position + 2'd1 : position - 2'd1;
                remaining_q <= remaining_q - 4'd1;
            end
        end
    end

    assign cmd_ready  = (state == IDLE);
    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    assign aborted    = aborted_q;
    assign remaining  = remaining_q;
    assign ClockValue = {1'b0, position, 1'b0};

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with DIV_MAX=3 (one step every 4 clk edges).
module tb_counter_sequencer;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_dir;
    logic [3:0] cmd_steps;
    logic       abort;
    logic       cmd_ready;
    logic [3:0] ClockValue;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [3:0] remaining;

    int n_tests = 0;
    int n_fail  = 0;

    counter_sequencer #(
        .DIV_W  (2),
        .DIV_MAX(2'd3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_dir   (cmd_dir),
        .cmd_steps (cmd_steps),
        .abort     (abort),
        .cmd_ready (cmd_ready),
        .ClockValue(ClockValue),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .remaining (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1ns past the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_cmd(input logic d, input logic [3:0] s, input logic [3:0] exp_cv, input string tag);
        cmd_valid = 1'b1;
        cmd_dir   = d;
        cmd_steps = s;
        tick(1);
        cmd_valid = 1'b0;
        check({tag, "_busy"}, busy, s != 4'd0);
        check({tag, "_aborted_clr"}, aborted, 1'b0);
        if (s != 4'd0) check({tag, "_rem_start"}, remaining, s);
        tick(4 * int'(s));
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_cv"}, ClockValue, exp_cv);
        check({tag, "_rem_end"}, remaining, 4'd0);
        tick(1);
        check({tag, "_ready"}, cmd_ready, 1'b1);
        check({tag, "_done_off"}, done, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_steps = 4'd0;
        abort     = 1'b0;

        // Reset values
        #12;
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_cv", ClockValue, 4'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_aborted", aborted, 1'b0);
        check("rst_rem", remaining, 4'd0);

        // up/3 offered right as reset drops: accepted on the first edge
        reset     = 1'b0;
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_steps = 4'd3;
        tick(1);
        cmd_valid = 1'b0;
        check("u3_busy", busy, 1'b1);
        check("u3_ready", cmd_ready, 1'b0);
        check("u3_rem0", remaining, 4'd3);
        tick(3);
        check("u3_cv_e3", ClockValue, 4'd0);
        tick(1);
        check("u3_cv_e4", ClockValue, 4'd2);
        check("u3_rem_e4", remaining, 4'd2);
        tick(4);
        check("u3_cv_e8", ClockValue, 4'd4);
        check("u3_rem_e8", remaining, 4'd1);
        tick(3);
        check("u3_cv_e11", ClockValue, 4'd4);
        check("u3_done_e11", done, 1'b0);
        tick(1);
        check("u3_cv_e12", ClockValue, 4'd6);
        check("u3_rem_e12", remaining, 4'd0);
        check("u3_done_e12", done, 1'b1);
        check("u3_busy_e12", busy, 1'b0);
        tick(1);
        check("u3_done_e13", done, 1'b0);
        check("u3_ready_e13", cmd_ready, 1'b1);

        // Wrap-around in both directions, from position 3
        do_cmd(1'b1, 4'd2, 4'd2, "up2_wrap");
        do_cmd(1'b0, 4'd1, 4'd0, "dn1");
        do_cmd(1'b0, 4'd1, 4'd6, "dn1_wrap");

        // Zero-step command
        do_cmd(1'b1, 4'd0, 4'd6, "zero");

        // cmd_valid held through RUN/DONE with a different command: taken only in IDLE
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_steps = 4'd1;
        tick(1);
        cmd_dir   = 1'b0;
        cmd_steps = 4'd2;
        check("hold_rem", remaining, 4'd1);
        tick(4);
        check("hold_done", done, 1'b1);
        check("hold_cv", ClockValue, 4'd0);
        tick(1);
        check("hold_idle", cmd_ready, 1'b1);
        tick(1);
        cmd_valid = 1'b0;
        check("hold_acc_busy", busy, 1'b1);
        check("hold_acc_rem", remaining, 4'd2);
        tick(8);
        check("hold2_done", done, 1'b1);
        check("hold2_cv", ClockValue, 4'd4);
        tick(1);

        // Reset mid-RUN, between edges
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_steps = 4'd5;
        tick(1);
        cmd_valid = 1'b0;
        tick(6);
        check("mid_cv_pre", ClockValue, 4'd6);
        #3;
        reset = 1'b1;
        #2;
        check("mid_ready", cmd_ready, 1'b1);
        check("mid_busy", busy, 1'b0);
        check("mid_cv", ClockValue, 4'd0);
        check("mid_rem", remaining, 4'd0);
        check("mid_done", done, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("mid_no_done", done, 1'b0);
        end

        // Abort coincident with the 2nd tick of up/5 from position 0
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_steps = 4'd5;
        tick(1);
        cmd_valid = 1'b0;
        tick(4);
        check("ab_cv_step1", ClockValue, 4'd2);
        tick(3);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("ab_done", done, 1'b1);
        check("ab_aborted", aborted, 1'b1);
        check("ab_cv", ClockValue, 4'd2);
        check("ab_rem", remaining, 4'd4);
        check("ab_busy", busy, 1'b0);
        tick(1);
        check("ab_ready", cmd_ready, 1'b1);
        check("ab_aborted_hold", aborted, 1'b1);

        // Abort in IDLE does nothing
        abort = 1'b1;
        tick(2);
        abort = 1'b0;
        check("idle_ab_ready", cmd_ready, 1'b1);
        check("idle_ab_done", done, 1'b0);
        check("idle_ab_cv", ClockValue, 4'd2);

        // Next accept clears aborted
        do_cmd(1'b0, 4'd1, 4'd0, "post_ab");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
